// File: rtl/block_nest_pkg.sv
// Shared constants, encodings and character helpers for the keyword-pair nesting checker.
package block_nest_pkg;

    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] CH_B  = 8'h62;
    localparam logic [7:0] CH_D  = 8'h64;
    localparam logic [7:0] CH_E  = 8'h65;
    localparam logic [7:0] CH_F  = 8'h66;
    localparam logic [7:0] CH_G  = 8'h67;
    localparam logic [7:0] CH_I  = 8'h69;
    localparam logic [7:0] CH_J  = 8'h6a;
    localparam logic [7:0] CH_K  = 8'h6b;
    localparam logic [7:0] CH_N  = 8'h6e;
    localparam logic [7:0] CH_O  = 8'h6f;
    localparam logic [7:0] CH_R  = 8'h72;

    localparam logic KIND_BEGIN = 1'b0;
    localparam logic KIND_FORK  = 1'b1;

    // Keyword index: bit 0 = close keyword, bit 1 = pair kind.
    localparam logic [1:0] KW_BEGIN = 2'd0;
    localparam logic [1:0] KW_END   = 2'd1;
    localparam logic [1:0] KW_FORK  = 2'd2;
    localparam logic [1:0] KW_JOIN  = 2'd3;

    typedef enum logic [1:0] {BOUNDARY = 2'd0, MATCH = 2'd1, SKIP = 2'd2, TENT = 2'd3} word_state_t;
    typedef enum logic [1:0] {NONE = 2'd0, PUSH = 2'd1, POP = 2'd2} pend_op_t;

    function automatic logic [7:0] to_lower(input logic [7:0] c);
        logic [7:0] r;
        if (c >= 8'h41 && c <= 8'h5a) r = c | 8'h20;
        else r = c;
        return r;
    endfunction

    function automatic logic [2:0] kw_len(input logic [1:0] kw);
        logic [2:0] r;
        case (kw)
            KW_BEGIN: r = 3'd5;
            KW_END:   r = 3'd3;
            default:  r = 3'd4;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] kw_char(input logic [1:0] kw, input logic [2:0] pos);
        logic [7:0] r;
        case ({kw, pos})
            {KW_BEGIN, 3'd0}: r = CH_B;
            {KW_BEGIN, 3'd1}: r = CH_E;
            {KW_BEGIN, 3'd2}: r = CH_G;
            {KW_BEGIN, 3'd3}: r = CH_I;
            {KW_BEGIN, 3'd4}: r = CH_N;
            {KW_END,   3'd0}: r = CH_E;
            {KW_END,   3'd1}: r = CH_N;
            {KW_END,   3'd2}: r = CH_D;
            {KW_FORK,  3'd0}: r = CH_F;
            {KW_FORK,  3'd1}: r = CH_O;
            {KW_FORK,  3'd2}: r = CH_R;
            {KW_FORK,  3'd3}: r = CH_K;
            {KW_JOIN,  3'd0}: r = CH_J;
            {KW_JOIN,  3'd1}: r = CH_O;
            {KW_JOIN,  3'd2}: r = CH_I;
            {KW_JOIN,  3'd3}: r = CH_N;
            default:          r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bnc_kind_stack.sv
// MAX_DEPTH x 1-bit LIFO of open-pair kinds; caller guarantees no push when full or pop when empty.
module bnc_kind_stack #(
    parameter int MAX_DEPTH = 16,
    parameter int DW        = $clog2(MAX_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          push_kind,
    output logic          top,
    output logic [DW-1:0] count,
    output logic          empty,
    output logic          full
);

    logic [MAX_DEPTH-1:0] mem_r;
    logic [DW-1:0]        count_r;
    logic                 top_s;

    assign empty = (count_r == '0);
    assign full  = (count_r == DW'(MAX_DEPTH));
    assign count = count_r;
    assign top   = top_s;

    // Entry storage: a push writes the slot just above the current top.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_r <= '0;
        end else begin
            for (int i = 0; i < MAX_DEPTH; i++) begin
                if (push && !full && count_r == DW'(i)) mem_r[i] <= push_kind;
            end
        end
    end

    // Occupancy counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_r <= '0;
        else if (push && !full) count_r <= count_r + DW'(1);
        else if (pop && !empty) count_r <= count_r - DW'(1);
        else count_r <= count_r;
    end

    // Top-of-stack read mux.
    always_comb begin
        top_s = 1'b0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            top_s = top_s | ((count_r == DW'(i + 1)) & mem_r[i]);
        end
    end

endmodule

// File: rtl/block_nest_checker.sv
// Streaming begin/end + fork/join nesting checker; keyword ops are tentative until the word-ending space.
module block_nest_checker
    import block_nest_pkg::*;
#(
    parameter int MAX_DEPTH = 16,
    parameter int DW        = $clog2(MAX_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    in,
    input  logic          in_valid,
    output logic          result,
    output logic          error,
    output logic [DW-1:0] depth,
    output logic [DW-1:0] max_depth
);

    word_state_t   state_r, state_s;
    pend_op_t      pend_r, pend_s;
    logic [3:0]    flags_r, flags_s, base_flags_s, hit_s, done_s;
    logic [2:0]    idx_r, idx_s, base_idx_s;
    logic [1:0]    done_kw_s;
    logic          kind_r, kind_s;
    logic          error_r, error_s, result_r, result_s;
    logic [DW-1:0] depth_r, depth_s, max_depth_r, max_depth_s;
    logic [7:0]    lc_s;
    logic          is_space_s, fault_cur_s, fault_nxt_s;
    logic          push_s, pop_s, top_s, empty_s, full_s;
    logic [DW-1:0] count_s;
    logic [DW:0]   cnt_ext_s, tdepth_s;

    function automatic logic op_fault(input pend_op_t op, input logic kind,
                                      input logic top, input logic empty, input logic full);
        logic r;
        case (op)
            PUSH:    r = full;
            POP:     r = empty || (top != kind);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    bnc_kind_stack #(.MAX_DEPTH(MAX_DEPTH), .DW(DW)) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .pop       (pop_s),
        .push_kind (kind_r),
        .top       (top_s),
        .count     (count_s),
        .empty     (empty_s),
        .full      (full_s)
    );

    assign lc_s       = to_lower(in);
    assign is_space_s = (in == SPACE);

    // Per-keyword candidate tracking for the current character.
    always_comb begin
        base_flags_s = (state_r == BOUNDARY) ? 4'b1111 : flags_r;
        base_idx_s   = (state_r == BOUNDARY) ? 3'd0 : idx_r;
        hit_s        = 4'b0000;
        done_s       = 4'b0000;
        done_kw_s    = 2'd0;
        for (int k = 0; k < 4; k++) begin
            hit_s[k]  = base_flags_s[k] && (base_idx_s < kw_len(2'(k)))
                        && (lc_s == kw_char(2'(k), base_idx_s));
            done_s[k] = hit_s[k] && ((base_idx_s + 3'd1) == kw_len(2'(k)));
            done_kw_s = done_kw_s | (done_s[k] ? 2'(k) : 2'd0);
        end
    end

    // Word FSM next state, tentative op capture and commit/cancel.
    always_comb begin
        state_s = state_r;
        flags_s = flags_r;
        idx_s   = idx_r;
        pend_s  = pend_r;
        kind_s  = kind_r;
        error_s = error_r;
        push_s  = 1'b0;
        pop_s   = 1'b0;
        if (in_valid) begin
            case (state_r)
                BOUNDARY, MATCH: begin
                    if (is_space_s) begin
                        state_s = BOUNDARY;
                    end else if (|done_s) begin
                        state_s = TENT;
                        pend_s  = done_kw_s[0] ? POP : PUSH;
                        kind_s  = done_kw_s[1] ? KIND_FORK : KIND_BEGIN;
                    end else if (|hit_s) begin
                        state_s = MATCH;
                        flags_s = hit_s;
                        idx_s   = base_idx_s + 3'd1;
                    end else begin
                        state_s = SKIP;
                    end
                end
                SKIP: state_s = is_space_s ? BOUNDARY : SKIP;
                TENT: begin
                    pend_s = NONE;
                    if (is_space_s) begin
                        state_s = BOUNDARY;
                        if (fault_cur_s) begin
                            error_s = 1'b1;
                        end else begin
                            push_s = (pend_r == PUSH);
                            pop_s  = (pend_r == POP);
                        end
                    end else begin
                        state_s = SKIP;
                    end
                end
                default: begin
                    state_s = BOUNDARY;
                    pend_s  = NONE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Next output values; a held pending op always sees an unchanged stack.
    always_comb begin
        fault_cur_s = op_fault(pend_r, kind_r, top_s, empty_s, full_s);
        fault_nxt_s = op_fault(pend_s, kind_s, top_s, empty_s, full_s);
        cnt_ext_s   = {1'b0, count_s};
        case (pend_s)
            PUSH:    tdepth_s = cnt_ext_s + (DW+1)'(1);
            POP:     tdepth_s = empty_s ? '0 : cnt_ext_s - (DW+1)'(1);
            default: tdepth_s = cnt_ext_s + (DW+1)'(push_s) - (DW+1)'(pop_s);
        endcase
        depth_s  = tdepth_s[DW] ? '1 : tdepth_s[DW-1:0];
        result_s = !error_s && !fault_nxt_s && (depth_s == '0);
        if (push_s && (depth_s > max_depth_r)) max_depth_s = depth_s;
        else max_depth_s = max_depth_r;
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= BOUNDARY;
            flags_r     <= 4'b0000;
            idx_r       <= 3'd0;
            pend_r      <= NONE;
            kind_r      <= 1'b0;
            error_r     <= 1'b0;
            result_r    <= 1'b1;
            depth_r     <= '0;
            max_depth_r <= '0;
        end else begin
            state_r     <= state_s;
            flags_r     <= flags_s;
            idx_r       <= idx_s;
            pend_r      <= pend_s;
            kind_r      <= kind_s;
            error_r     <= error_s;
            result_r    <= result_s;
            depth_r     <= depth_s;
            max_depth_r <= max_depth_s;
        end
    end

    assign result    = result_r;
    assign error     = error_r;
    assign depth     = depth_r;
    assign max_depth = max_depth_r;

endmodule

// File: tb/tb_block_nest_checker.sv
// Directed + random bench for block_nest_checker against a word-level reference model.
module tb_block_nest_checker;

    localparam int MAXD = 4;
    localparam int DW   = $clog2(MAXD + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    in;
    logic          in_valid;
    logic          result, error;
    logic [DW-1:0] depth, max_depth;

    int    total = 0;
    int    bad   = 0;
    bit    stk[$];
    bit    m_err;
    int    m_max;
    string m_word;

    always #5 clk = ~clk;

    block_nest_checker #(.MAX_DEPTH(MAXD)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .in_valid  (in_valid),
        .result    (result),
        .error     (error),
        .depth     (depth),
        .max_depth (max_depth)
    );

    // 0 = not a keyword, 1 begin, 2 end, 3 fork, 4 join
    function automatic int classify(string w);
        string l;
        l = w.tolower();
        if (l == "begin") return 1;
        if (l == "end")   return 2;
        if (l == "fork")  return 3;
        if (l == "join")  return 4;
        return 0;
    endfunction

    function automatic bit is_open(int op);
        return (op == 1) || (op == 3);
    endfunction

    function automatic bit op_kind(int op);
        return (op >= 3);
    endfunction

    function automatic bit faults(int op);
        if (op == 0) return 1'b0;
        if (is_open(op)) return stk.size() >= MAXD;
        if (stk.size() == 0) return 1'b1;
        return stk[$] != op_kind(op);
    endfunction

    task automatic model_reset();
        stk.delete();
        m_err  = 1'b0;
        m_max  = 0;
        m_word = "";
    endtask

    task automatic model_feed(byte ch);
        int op;
        if (ch == 8'h20) begin
            if (m_word.len() > 0) begin
                op = classify(m_word);
                if (op != 0) begin
                    if (faults(op)) m_err = 1'b1;
                    else if (is_open(op)) begin
                        stk.push_back(op_kind(op));
                        if (stk.size() > m_max) m_max = stk.size();
                    end else void'(stk.pop_back());
                end
            end
            m_word = "";
        end else begin
            m_word = $sformatf("%s%c", m_word, ch);
        end
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        int op;
        int d;
        bit exp_res;
        op = (m_word.len() > 0) ? classify(m_word) : 0;
        d  = stk.size();
        if (is_open(op)) d++;
        else if (op != 0 && d > 0) d--;
        exp_res = !m_err && !faults(op) && (d == 0);
        check({tag, "/result"}, {31'd0, result}, {31'd0, exp_res});
        check({tag, "/error"}, {31'd0, error}, {31'd0, m_err});
        check({tag, "/depth"}, 32'(depth), 32'(d));
        check({tag, "/max_depth"}, 32'(max_depth), 32'(m_max));
    endtask

    task automatic step(byte ch, bit v);
        in       = ch;
        in_valid = v;
        @(posedge clk);
        #1;
        if (v) model_feed(ch);
        check_all($sformatf("chr_%02h_v%0d", ch, v));
    endtask

    task automatic send(string s);
        for (int i = 0; i < s.len(); i++) step(s[i], 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all("reset");
        #2;
        reset = 1'b0;
    endtask

    string toks[14] = '{"begin", "end", "fork", "join", "BeGin", "END", "Fork", "JOIN",
                        "ended", "beg", "joins", "x@", "forkbegin", "enD"};

    initial begin
        in       = 8'h00;
        in_valid = 1'b0;
        model_reset();
        do_reset();

        send("begin end ");

        do_reset();
        send("beginx end ");
        send("begin end ");

        do_reset();
        send("begin fork end ");

        do_reset();
        send("BeGiN FoRk JOIN End ");

        do_reset();
        send("begin begin begin begin begin ");
        send("end end end end ");

        do_reset();
        send("fork begin end join");
        send("  join ");

        do_reset();
        send("begin");
        for (int i = 0; i < 3; i++) step(8'($urandom_range(33, 126)), 1'b0);
        do_reset();

        for (int seg = 0; seg < 25; seg++) begin
            do_reset();
            for (int t = 0; t < 30; t++) begin
                string tok;
                tok = toks[$urandom_range(0, 13)];
                for (int c = 0; c < tok.len(); c++) begin
                    if ($urandom_range(0, 4) == 0) step(8'($urandom_range(33, 126)), 1'b0);
                    step(tok[c], 1'b1);
                end
                if ($urandom_range(0, 3) != 0) step(8'h20, 1'b1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
